keypad_hex_entry: RTL and testbench
===================================

// Module: keypad_hex_entry
// PURPOSE
//   Scans a 4x4 matrix keypad and debounces it. Each accepted keypress shifts
//   one hex nibble into a 32-bit entry register. The register drives the
//   8-digit seven-segment display path, so this block is the input end of the
//   hex display interface.
//   One key is accepted per press. A key must be fully released before the
//   next key is accepted.
// PARAMETERS
//   SCAN_DIV_BITS  17       column dwell = 2**SCAN_DIV_BITS clk cycles
//   DEBOUNCE_CNT   1000000  stable cycles required for press and for release (10 ms @100 MHz)
//   CNT_W          20       debounce counter width; must satisfy 2**CNT_W > DEBOUNCE_CNT
// PORTS
//   clk        in   1   system clock
//   rst_n      in   1   asynchronous reset, active low
//   row        in   4   keypad rows, active low, externally pulled up, asynchronous to clk
//   col        out  4   keypad column drive, active low, exactly one bit low
//   value      out  32  entry register; nibble [3:0] holds the newest key
//   key_code   out  4   code of the last accepted key
//   key_valid  out  1   1-cycle pulse when a key is accepted
//   key_held   out  1   1 while an accepted key has not yet been released
// BEHAVIOUR
//   - Input sync: row passes through a 2-FF synchroniser (row_s). All decisions use row_s.
//   - Reset values: col=4'b1110, value=0, key_code=0, key_valid=0, key_held=0,
//     state=SCAN, column index=0, all counters=0.
//   - Key map (row r, col c -> code):
//       r0: 1 2 3 A
//       r1: 4 5 6 B
//       r2: 7 8 9 C
//       r3: 0 F E D
//   - FSM:
//     SCAN:
//       - Drive col=~(1<<c). The dwell counter counts 2**SCAN_DIV_BITS cycles.
//       - On the last dwell cycle, sample row_s.
//       - If any bit is low, latch r = lowest-index low row and latch c, clear the
//         debounce counter, and go to DEBOUNCE. Otherwise c <= c+1 (3 wraps to 0),
//         the dwell counter restarts, and the FSM stays in SCAN.
//     DEBOUNCE:
//       - col is held. Each cycle with row_s[r]==0 increments the counter.
//       - If row_s[r]==1 (bounce), go to SCAN with c <= c+1. No output change.
//       - When the counter reaches DEBOUNCE_CNT-1 with the row still low, go to ACCEPT.
//     ACCEPT (1 cycle):
//       - key_valid=1, key_code=map(r,c), value <= {value[27:0], map(r,c)}, key_held=1.
//       - Next state is RELEASE.
//     RELEASE:
//       - col is held. The counter increments while row_s==4'b1111 and clears to 0
//         on any low bit.
//       - At DEBOUNCE_CNT-1: key_held=0, c <= c+1, go to SCAN.
//   - Latency: from the dwell sample that sees the press to key_valid is exactly
//     DEBOUNCE_CNT+1 cycles.
//   - key_valid is high for exactly one cycle per accepted press. A held key never repeats.
//   - Simultaneous keys:
//     - Same column: lowest row wins.
//     - Different columns: the first column scanned wins.
//     - Any key pressed during RELEASE is ignored, and it also delays release completion.
//   - value shifts left 4 bits per key. The oldest nibble drops off the top; there is
//     no saturation. Only rst_n clears value.
//   - An rst_n assert in any state immediately forces all reset values. No key_valid
//     is emitted for a press that was in progress.
// TESTING (sim: SCAN_DIV_BITS=2, DEBOUNCE_CNT=8)
//   1. Release reset with no key -> col=1110; col then cycles 1101,1011,0111,1110
//      every 4 cycles; value=0; key_valid never 1.
//   2. Hold row1 low while col2 is driven, for 60 cycles, then release -> one
//      key_valid, key_code=6, value=0x00000006, key_held 1 until 8 high cycles after release.
//   3. Bounce: row0 low for 3 cycles during col0, then high -> no key_valid;
//      scanning resumes at col1.
//   4. Enter keys 1,2,...,9 in sequence -> value=0x23456789 after the ninth pulse;
//      nine key_valid pulses total.
//   5. Hold key 'D' (r3,c3) 500 cycles with a 2-cycle high glitch 4 cycles into the
//      release -> one pulse with code D; release completes 8 cycles after the glitch ends.
//   6. Assert rst_n during DEBOUNCE of key '5' -> outputs go to reset values at once;
//      no key_valid; value stays 0.

Source files
------------

// File: rtl/keypad_hex_entry.sv
// 4x4 matrix keypad scanner with press/release debounce; each accepted key
// shifts one hex nibble into a 32-bit entry register.
module keypad_hex_entry #(
  parameter int SCAN_DIV_BITS = 17,
  parameter int DEBOUNCE_CNT  = 1000000,
  parameter int CNT_W         = 20
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [3:0]  row,
  output logic [3:0]  col,
  output logic [31:0] value,
  output logic [3:0]  key_code,
  output logic        key_valid,
  output logic        key_held
);

  typedef enum logic [1:0] {
    SCAN     = 2'd0,
    DEBOUNCE = 2'd1,
    ACCEPT   = 2'd2,
    RELEASE  = 2'd3
  } state_t;

  localparam logic [CNT_W-1:0]         CNT_LAST   = CNT_W'(DEBOUNCE_CNT - 1);
  localparam logic [SCAN_DIV_BITS-1:0] DWELL_LAST = '1;

  function automatic logic [3:0] key_map(input logic [1:0] r, input logic [1:0] c);
    logic [3:0] code;
    case ({r, c})
      4'b00_00: code = 4'h1;
      4'b00_01: code = 4'h2;
      4'b00_10: code = 4'h3;
      4'b00_11: code = 4'hA;
      4'b01_00: code = 4'h4;
      4'b01_01: code = 4'h5;
      4'b01_10: code = 4'h6;
      4'b01_11: code = 4'hB;
      4'b10_00: code = 4'h7;
      4'b10_01: code = 4'h8;
      4'b10_10: code = 4'h9;
      4'b10_11: code = 4'hC;
      4'b11_00: code = 4'h0;
      4'b11_01: code = 4'hF;
      4'b11_10: code = 4'hE;
      default:  code = 4'hD;
    endcase
    return code;
  endfunction

  // Lowest-index active-low row wins when several rows in a column are down.
  function automatic logic [1:0] low_row(input logic [3:0] rs);
    logic [1:0] idx;
    casez (rs)
      4'b???0: idx = 2'd0;
      4'b??01: idx = 2'd1;
      4'b?011: idx = 2'd2;
      default: idx = 2'd3;
    endcase
    return idx;
  endfunction

  logic [3:0]               row_meta_q, row_s_q;
  state_t                   state_q, state_d;
  logic [1:0]               col_idx_q, col_idx_d;
  logic [1:0]               row_idx_q, row_idx_d;
  logic [SCAN_DIV_BITS-1:0] dwell_q, dwell_d;
  logic [CNT_W-1:0]         cnt_q, cnt_d;
  logic [31:0]              value_q, value_d;
  logic [3:0]               key_code_q, key_code_d;
  logic                     key_valid_q, key_valid_d;
  logic                     key_held_q, key_held_d;
  logic [3:0]               accept_code;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      row_meta_q <= 4'hF;
      row_s_q    <= 4'hF;
    end else begin
      row_meta_q <= row;
      row_s_q    <= row_meta_q;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= SCAN;
      col_idx_q   <= 2'd0;
      row_idx_q   <= 2'd0;
      dwell_q     <= '0;
      cnt_q       <= '0;
      value_q     <= 32'h0;
      key_code_q  <= 4'h0;
      key_valid_q <= 1'b0;
      key_held_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      col_idx_q   <= col_idx_d;
      row_idx_q   <= row_idx_d;
      dwell_q     <= dwell_d;
      cnt_q       <= cnt_d;
      value_q     <= value_d;
      key_code_q  <= key_code_d;
      key_valid_q <= key_valid_d;
      key_held_q  <= key_held_d;
    end
  end

  assign accept_code = key_map(row_idx_q, col_idx_q);

  // Outputs are loaded on the edge that enters ACCEPT so they are visible
  // during the ACCEPT cycle itself.
  always_comb begin
    state_d     = state_q;
    col_idx_d   = col_idx_q;
    row_idx_d   = row_idx_q;
    dwell_d     = '0;
    cnt_d       = cnt_q;
    value_d     = value_q;
    key_code_d  = key_code_q;
    key_valid_d = 1'b0;
    key_held_d  = key_held_q;
    case (state_q)
      SCAN: begin
        dwell_d = dwell_q + 1'b1;
        if (dwell_q == DWELL_LAST) begin
          if (row_s_q != 4'hF) begin
            row_idx_d = low_row(row_s_q);
            cnt_d     = '0;
            dwell_d   = '0;
            state_d   = DEBOUNCE;
          end else begin
            col_idx_d = col_idx_q + 2'd1;
          end
        end
      end
      DEBOUNCE: begin
        if (row_s_q[row_idx_q]) begin
          col_idx_d = col_idx_q + 2'd1;
          state_d   = SCAN;
        end else if (cnt_q == CNT_LAST) begin
          key_valid_d = 1'b1;
          key_code_d  = accept_code;
          value_d     = {value_q[27:0], accept_code};
          key_held_d  = 1'b1;
          state_d     = ACCEPT;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      ACCEPT: begin
        cnt_d   = '0;
        state_d = RELEASE;
      end
      RELEASE: begin
        if (row_s_q != 4'hF) begin
          cnt_d = '0;
        end else if (cnt_q == CNT_LAST) begin
          cnt_d      = '0;
          key_held_d = 1'b0;
          col_idx_d  = col_idx_q + 2'd1;
          state_d    = SCAN;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      default: state_d = SCAN;
    endcase
  end

  assign col       = ~(4'b0001 << col_idx_q);
  assign value     = value_q;
  assign key_code  = key_code_q;
  assign key_valid = key_valid_q;
  assign key_held  = key_held_q;

endmodule

// File: tb/tb_keypad_hex_entry.sv
// Bench for keypad_hex_entry: keypad matrix model, scoreboard of expected
// accepted keys, and directed timing checks around press/release.
module tb_keypad_hex_entry;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [3:0]  row;
  logic [3:0]  col;
  logic [31:0] value;
  logic [3:0]  key_code;
  logic        key_valid;
  logic        key_held;

  keypad_hex_entry #(
    .SCAN_DIV_BITS(2),
    .DEBOUNCE_CNT (8),
    .CNT_W        (4)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .row      (row),
    .col      (col),
    .value    (value),
    .key_code (key_code),
    .key_valid(key_valid),
    .key_held (key_held)
  );

  always #5 clk = ~clk;

  // Keypad: pressed[r*4+c] shorts row r to column c.
  logic [15:0] pressed;
  always_comb begin
    row = 4'hF;
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < 4; c++)
        if (pressed[r*4+c] && !col[c]) row[r] = 1'b0;
  end

  logic [3:0] kmap [4][4] = '{'{4'h1, 4'h2, 4'h3, 4'hA},
                              '{4'h4, 4'h5, 4'h6, 4'hB},
                              '{4'h7, 4'h8, 4'h9, 4'hC},
                              '{4'h0, 4'hF, 4'hE, 4'hD}};

  typedef struct packed {
    logic [3:0]  code;
    logic [31:0] value;
  } exp_t;

  exp_t        q[$];
  exp_t        mon_e;
  logic [31:0] exp_value;
  int          checks   = 0;
  int          failures = 0;
  int          pulses   = 0;
  int          pushed   = 0;
  logic        prev_kv  = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%h required=%h", name, act, req);
    end
  endtask

  task automatic expect_key(input int r, input int c);
    logic [3:0] code;
    code      = kmap[r][c];
    exp_value = {exp_value[27:0], code};
    q.push_back('{code, exp_value});
    pushed++;
  endtask

  // Returns at the first negedge after col switches to target (dwell start).
  task automatic wait_col(input logic [3:0] target);
    logic [3:0] prev;
    logic       ok;
    prev = col;
    ok   = 1'b0;
    for (int i = 0; i < 80; i++) begin
      @(negedge clk);
      if (col == target && prev != target) begin
        ok = 1'b1;
        break;
      end
      prev = col;
    end
    chk("wait_col", {31'b0, ok}, 32'd1);
  endtask

  always @(negedge clk) begin
    if (rst_n) begin
      if (prev_kv) chk("key_valid_width", {31'b0, key_valid}, 32'd0);
      if (key_valid) begin
        pulses++;
        if (q.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL unexpected_key_valid actual_code=%h required=no_pulse", key_code);
        end else begin
          mon_e = q.pop_front();
          chk("key_code", {28'b0, key_code}, {28'b0, mon_e.code});
          chk("value", value, mon_e.value);
          chk("key_held_on_accept", {31'b0, key_held}, 32'd1);
        end
      end
      prev_kv <= key_valid;
    end else begin
      prev_kv <= 1'b0;
    end
  end

  initial begin
    #1000000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int         r, c, r2, hold, gl;
    logic [3:0] ecol;
    rst_n     = 1'b0;
    pressed   = 16'h0;
    exp_value = 32'h0;
    repeat (3) @(negedge clk);
    chk("rst_col", {28'b0, col}, 32'hE);
    chk("rst_value", value, 32'h0);
    chk("rst_key_code", {28'b0, key_code}, 32'h0);
    chk("rst_key_valid", {31'b0, key_valid}, 32'd0);
    chk("rst_key_held", {31'b0, key_held}, 32'd0);
    rst_n = 1'b1;

    // Idle scan sequence
    wait_col(4'b1101);
    for (int i = 0; i < 16; i++) begin
      ecol = ~(4'b0001 << ((1 + i / 4) % 4));
      chk("scan_col", {28'b0, col}, {28'b0, ecol});
      @(negedge clk);
    end
    chk("idle_value", value, 32'h0);

    // Key 6 (row1, col2): exact accept latency and release timing
    wait_col(4'b1011);
    expect_key(1, 2);
    pressed[1*4+2] = 1'b1;
    repeat (11) @(negedge clk);
    chk("latency_before", {31'b0, key_valid}, 32'd0);
    @(negedge clk);
    chk("latency_at", {31'b0, key_valid}, 32'd1);
    repeat (48) @(negedge clk);
    chk("key6_value", value, 32'h00000006);
    chk("key6_held", {31'b0, key_held}, 32'd1);
    pressed = 16'h0;
    repeat (9) @(negedge clk);
    chk("release_held_still", {31'b0, key_held}, 32'd1);
    @(negedge clk);
    chk("release_held_clear", {31'b0, key_held}, 32'd0);
    chk("release_next_col", {28'b0, col}, 32'h7);

    // Bounce on row0/col0
    wait_col(4'b1110);
    @(negedge clk);
    pressed[0] = 1'b1;
    repeat (3) @(negedge clk);
    pressed = 16'h0;
    repeat (2) @(negedge clk);
    chk("bounce_col_held", {28'b0, col}, 32'hE);
    @(negedge clk);
    chk("bounce_resume_col1", {28'b0, col}, 32'hD);
    repeat (10) @(negedge clk);

    // Randomized presses, some with two rows in one column, plus glitches
    for (int n = 0; n < 12; n++) begin
      r = $urandom_range(0, 3);
      c = $urandom_range(0, 3);
      pressed = 16'h0;
      pressed[r*4+c] = 1'b1;
      if ($urandom_range(0, 3) == 0) begin
        r2 = (r + 1 + $urandom_range(0, 2)) % 4;
        pressed[r2*4+c] = 1'b1;
        if (r2 < r) r = r2;
      end
      expect_key(r, c);
      hold = $urandom_range(40, 80);
      repeat (hold) @(negedge clk);
      pressed = 16'h0;
      repeat (20) @(negedge clk);
      chk("rand_held_cleared", {31'b0, key_held}, 32'd0);
      gl = $urandom_range(1, 6);
      pressed[$urandom_range(0, 15)] = 1'b1;
      repeat (gl) @(negedge clk);
      pressed = 16'h0;
      repeat (12) @(negedge clk);
    end

    // Keys 1..9 in sequence
    for (int k = 1; k <= 9; k++) begin
      expect_key((k - 1) / 3, (k - 1) % 3);
      pressed[((k - 1) / 3) * 4 + (k - 1) % 3] = 1'b1;
      repeat (50) @(negedge clk);
      pressed = 16'h0;
      repeat (20) @(negedge clk);
    end
    chk("seq_value", value, 32'h23456789);

    // Long hold of D with a glitch during release
    expect_key(3, 3);
    pressed[15] = 1'b1;
    repeat (500) @(negedge clk);
    pressed = 16'h0;
    repeat (4) @(negedge clk);
    pressed[15] = 1'b1;
    repeat (2) @(negedge clk);
    pressed = 16'h0;
    repeat (9) @(negedge clk);
    chk("glitch_held_still", {31'b0, key_held}, 32'd1);
    @(negedge clk);
    chk("glitch_held_clear", {31'b0, key_held}, 32'd0);
    chk("glitch_next_col", {28'b0, col}, 32'hE);
    chk("pending_before_reset", q.size(), 32'd0);

    // Reset while debouncing key 5
    wait_col(4'b1101);
    pressed[1*4+1] = 1'b1;
    repeat (6) @(negedge clk);
    rst_n     = 1'b0;
    exp_value = 32'h0;
    #1;
    chk("midrst_col", {28'b0, col}, 32'hE);
    chk("midrst_value", value, 32'h0);
    chk("midrst_key_code", {28'b0, key_code}, 32'h0);
    chk("midrst_key_valid", {31'b0, key_valid}, 32'd0);
    chk("midrst_key_held", {31'b0, key_held}, 32'd0);
    pressed = 16'h0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (40) @(negedge clk);
    chk("postrst_value", value, 32'h0);

    repeat (20) @(negedge clk);
    chk("pending_final", q.size(), 32'd0);
    chk("pulse_count", pulses, pushed);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
